// File: rtl/snow64_ext_data_access_bridge.sv
// snow64_ext_data_access_bridge: serialises one LAR-width CPU access into narrow
// req/ack bus beats and returns the assembled read data or a write completion.
module snow64_ext_data_access_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LAR_DATA_WIDTH = 256,
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_req,
  input  logic                      in_access_type,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [LAR_DATA_WIDTH-1:0] in_data,
  output logic                      out_valid,
  output logic [LAR_DATA_WIDTH-1:0] out_data,
  output logic                      busy,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
  input  logic                      bus_ack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_rdata
);
  localparam int NUM_BEATS  = LAR_DATA_WIDTH / BUS_DATA_WIDTH;
  localparam int BEAT_BYTES = BUS_DATA_WIDTH / 8;
  localparam int LINE_BYTES = LAR_DATA_WIDTH / 8;
  localparam int CW         = NUM_BEATS > 1 ? $clog2(NUM_BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StBeat, StDone} stateT;

  stateT                     state, nextState;
  logic [CW-1:0]             count;
  logic [ADDR_WIDTH-1:0]     base;
  logic                      isWrite;
  logic [LAR_DATA_WIDTH-1:0] wrData, rdBuf, outDataReg;
  logic                      lastBeat;

  assign lastBeat = count == CW'(NUM_BEATS - 1);

  always_ff @(posedge clk)
    if (!rst_n) state <= StIdle;
    else        state <= nextState;

  always_comb begin
    nextState = state;
    nextState = state == StIdle ? (in_req ? StBeat : StIdle)
              : state == StBeat ? (bus_ack && lastBeat ? StDone : StBeat)
              : StIdle;
  end

  assign busy      = state != StIdle;
  assign bus_req   = state == StBeat;
  assign bus_we    = bus_req && isWrite;
  assign bus_addr  = base + ADDR_WIDTH'(count) * ADDR_WIDTH'(BEAT_BYTES);
  assign bus_wdata = wrData[count*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  assign out_valid = state == StDone;
  // Completion data is shown live in DONE and then frozen for later cycles.
  assign out_data  = out_valid ? (isWrite ? '0 : rdBuf) : outDataReg;

  always_ff @(posedge clk)
    if (!rst_n) begin
      count      <= '0;
      base       <= '0;
      isWrite    <= 1'b0;
      wrData     <= '0;
      rdBuf      <= '0;
      outDataReg <= '0;
    end else begin
      if (state == StIdle && in_req) begin
        isWrite <= in_access_type;
        base    <= in_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
        wrData  <= in_data;
        count   <= '0;
      end
      if (state == StBeat && bus_ack) begin
        if (!isWrite) rdBuf[count*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_rdata;
        if (!lastBeat) count <= count + 1'b1;
      end
      if (state == StDone) outDataReg <= out_data;
    end
endmodule

// File: doc/snow64_ext_data_access_bridge.md
Name: snow64_ext_data_access_bridge

Overview:
- Sits directly downstream of the CPU's external-data-access output for memory or port-mapped IO.
- Accepts one full LAR-width request: req, access type, address and data.
- Serialises it into a sequence of narrower beats on an external bus with a req/ack handshake.
- Returns the assembled read data, or a write completion, to the CPU's external-data-access input as a one-cycle valid pulse.

Parameters:
- ADDR_WIDTH, 64, width of CPU and bus addresses.
- LAR_DATA_WIDTH, 256, width of one CPU data transfer (one LAR line).
- BUS_DATA_WIDTH, 64, external bus beat width. Must be a power of two and must divide LAR_DATA_WIDTH.
- Derived, not overridable: NUM_BEATS = LAR_DATA_WIDTH/BUS_DATA_WIDTH (default 4); BEAT_BYTES = BUS_DATA_WIDTH/8; LINE_BYTES = LAR_DATA_WIDTH/8.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_req  in  1  CPU request; sampled only in IDLE.
- in_access_type  in  1  0 = read (ExtDataAccTypRead), 1 = write (ExtDataAccTypWrite).
- in_addr  in  ADDR_WIDTH  CPU byte address.
- in_data  in  LAR_DATA_WIDTH  write data.
- out_valid  out  1  one-cycle completion pulse to CPU.
- out_data  out  LAR_DATA_WIDTH  assembled read data; 0 on write completion.
- busy  out  1  high whenever state is not IDLE.
- bus_req  out  1  beat request, held until acked.
- bus_we  out  1  beat is a write.
- bus_addr  out  ADDR_WIDTH  beat byte address.
- bus_wdata  out  BUS_DATA_WIDTH  beat write data.
- bus_ack  in  1  beat accepted/complete; valid only while bus_req=1.
- bus_rdata  in  BUS_DATA_WIDTH  beat read data; sampled in the bus_ack cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - out_valid, busy, bus_req and bus_we become 0.
  - bus_addr, bus_wdata and out_data become 0.
  - Beat counter and data buffer are cleared.
- Reset mid-transaction: abort with no out_valid. bus_req is low in the cycle after the reset edge. Partial read data is discarded.
- States: IDLE, BEAT, DONE.
- IDLE:
  - If in_req=1, latch the following and go to BEAT:
    - access type;
    - line base = in_addr with the low log2(LINE_BYTES) bits forced to 0 (unaligned addresses are silently aligned);
    - in_data.
  - Beat counter is set to 0.
- BEAT:
  - bus_req=1.
  - bus_we = latched type.
  - bus_addr = base + count*BEAT_BYTES.
  - bus_wdata = latched data[count*BUS_DATA_WIDTH +: BUS_DATA_WIDTH].
  - On bus_ack=1 for a read, store bus_rdata into buffer slot `count`. Beat 0 is bits [BUS_DATA_WIDTH-1:0] (little-endian beat order).
  - On bus_ack=1, if count = NUM_BEATS-1 go to DONE; otherwise increment count and stay in BEAT. bus_req stays high with the advanced address on the next cycle (back-to-back beats, no idle gap).
  - bus_ack=0: hold all bus outputs stable.
- DONE:
  - out_valid=1 for exactly one cycle.
  - out_data = buffer for a read, 0 for a write.
  - bus_req=0. Next state is IDLE.
- out_valid is 0 in all other states. out_data holds its last value outside DONE.
- Latency with zero-wait-state bus: request accepted at edge T, beats at cycles T+1..T+NUM_BEATS, out_valid in cycle T+NUM_BEATS+1. Each ack wait cycle adds one cycle.
- in_req while busy=1 (including DONE) is ignored. No queueing, no error flag. The CPU must wait for out_valid before issuing a new request.
- bus_ack while bus_req=0 is ignored.
- Address arithmetic is ADDR_WIDTH-bit. Beats never cross the aligned line, so there is no carry out. The topmost line (all-ones upper bits, base = 2^ADDR_WIDTH - LINE_BYTES) produces beat addresses up to 2^ADDR_WIDTH - BEAT_BYTES without wrap.
- No timeout: an ack that never comes stalls the block indefinitely.

Test Plan:
- Read at in_addr 0x1000, bus_ack tied 1, bus_rdata = 0x11..11, 0x22..22, 0x33..33, 0x44..44 per beat:
  - bus_addr 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles;
  - out_valid 5 cycles after accept;
  - out_data = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write at 0x2000 with in_data = {D3, D2, D1, D0}, bus_ack delayed 2 cycles per beat:
  - bus_we=1 on every beat, bus_wdata = D0..D3 in order, each held stable during waits;
  - out_valid once after 13 cycles with out_data=0.
- Unaligned read at 0xFFFF_FFFF_FFFF_FFF7 -> beats at 0x...FFE0, FFE8, FFF0, FFF8; no wrap to 0; normal completion.
- in_req pulsed during beat 2 and again during DONE -> both ignored; exactly one out_valid; bus sequence unchanged.
- rst_n=0 for one cycle after beat 1 acks -> bus_req=0 next cycle, busy=0, no out_valid; a subsequent read at 0x40 completes normally with fresh data.
- bus_ack=1 asserted while idle -> no state change, no out_valid.
